// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a register-bank FIFO (holds no data).
// Optional almost-full/almost-empty flags under `FIFO_ALMOST_FLAGS_EN.
module fifo_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int ALMOST_FULL_TH  = DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = 1
`endif
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              wr,
  input  logic              rd,
  output logic [DEPTH-1:0]  wr_en_vec,
  output logic [ADDR_W-1:0] rd_sel,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push, pop;
  // rst_ gates the enables so no entry register is written while reset is held
  assign push      = wr & ~full & rst_;
  assign pop       = rd & ~empty;
  assign rd_sel    = rd_ptr;
  assign count_nxt = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  always_comb begin
    wr_en_vec         = '0;
    wr_en_vec[wr_ptr] = push;
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + ADDR_W'(push);
      rd_ptr    <= rd_ptr + ADDR_W'(pop);
      count     <= count_nxt;
      full      <= count_nxt == (ADDR_W+1)'(DEPTH);
      empty     <= count_nxt == '0;
      overflow  <= wr & full;
      underflow <= rd & empty;
    end
  end
`ifdef FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= count_nxt >= (ADDR_W+1)'(ALMOST_FULL_TH);
      almost_empty <= count_nxt <= (ADDR_W+1)'(ALMOST_EMPTY_TH);
    end
  end
`endif
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the register-bank FIFO. It sits directly upstream of the per-entry data registers.
- It drives one one-hot enable per entry to steer the write data into the correct register.
- It supplies the read-select index used by the output mux.
- It tracks occupancy and produces full/empty plus error pulses.
- It holds no data; the payload lives entirely in the downstream register instances.

Parameters:
DEPTH, 8, number of entries in the register bank; power of two, >= 2
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_  input  1  asynchronous active-low reset
wr  input  1  push request for the current cycle
rd  input  1  pop request for the current cycle
wr_en_vec  output  DEPTH  one-hot enable to the entry registers; bit i drives the en of entry i
rd_sel  output  ADDR_W  index of the oldest valid entry, used by the read mux
count  output  ADDR_W+1  number of valid entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  one-cycle pulse: a push was rejected
underflow  output  1  one-cycle pulse: a pop was rejected

Behaviour:
- Clock and reset: clk, plus asynchronous active-low reset rst_. All state clears immediately when rst_ falls, independent of clk.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, rd_sel = 0, count = 0
  - empty = 1, full = 0, overflow = 0, underflow = 0
  - wr_en_vec = 0 for as long as rst_ is low.
- Push acceptance: a push is accepted when wr = 1 and full = 0.
  - When full = 1 a push is always rejected, even if rd = 1 in the same cycle. This is a decided rule; there is no pass-through on full.
- Pop acceptance: a pop is accepted when rd = 1 and empty = 0.
  - When empty = 1 a pop is always rejected, even if wr = 1 in the same cycle.
- wr_en_vec: combinational. It equals (1 << wr_ptr) in any cycle where a push is accepted, and 0 otherwise. The addressed register therefore captures data on the same rising edge that advances wr_ptr, giving zero-cycle latency from wr to storage.
- rd_sel: driven directly from registered rd_ptr.
  - The read data (mux of the register outputs at rd_sel) is valid whenever empty = 0.
  - An accepted pop advances rd_ptr at the edge, so the next entry is presented in the following cycle.
- Pointer wrap: each pointer increments modulo DEPTH (natural ADDR_W-bit wrap), DEPTH-1 -> 0.
- Count update per edge:
  - +1 on push only
  - -1 on pop only
  - unchanged when both are accepted or neither is
  - count is never allowed to go outside 0..DEPTH.
- Flags: full and empty are registered, derived from the next count value, and valid in the cycle after the edge that changes count.
- Simultaneous push and pop with 0 < count < DEPTH: both are accepted; both pointers advance and count holds.
- Error pulses:
  - overflow = 1 for exactly the cycle after an edge where wr = 1 and full = 1.
  - underflow is the same for rd = 1 and empty = 1.
  - Rejected requests change no state.
- Reset mid-operation: all pointers, count and flags return to their reset values. Entry register contents are don't-care afterwards because empty = 1 masks them.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined:
  - Adds parameter ALMOST_FULL_TH (default DEPTH-1) and parameter ALMOST_EMPTY_TH (default 1).
  - Adds output ports almost_full (registered, count >= ALMOST_FULL_TH) and almost_empty (registered, count <= ALMOST_EMPTY_TH).
  - Both outputs update on the same edge as full/empty. Reset values: almost_full = 0, almost_empty = 1.
- Undefined: neither the parameters nor the ports exist; all other behaviour is identical.

Test Plan:
All scenarios use DEPTH = 4.
- Reset: drive rst_ = 0 mid-cycle with wr = 1 -> wr_en_vec = 0 immediately; after release count = 0, empty = 1, full = 0, rd_sel = 0.
- Fill: 4 consecutive cycles with wr = 1, rd = 0 -> wr_en_vec sequence 0001, 0010, 0100, 1000; count 1, 2, 3, 4; full = 1 after the 4th edge.
- Overflow: while full, wr = 1 for 1 cycle -> wr_en_vec = 0, count stays 4, overflow = 1 for exactly one cycle, wr_ptr unchanged.
- Drain and wrap:
  - From full, 4 cycles with rd = 1 -> rd_sel 0, 1, 2, 3 then back to 0; empty = 1 after the 4th edge.
  - A 5th rd gives underflow = 1 for one cycle.
- Simultaneous push and pop:
  - With count = 2, wr = rd = 1 for 3 cycles -> count holds at 2, and wr_en_vec / rd_sel both wrap past index 3.
  - With count = 0, wr = rd = 1 -> push accepted, pop rejected, count = 1, underflow = 1.
- FIFO_ALMOST_FLAGS_EN with defaults:
  - Push 3 -> almost_full rises with count = 3, and full stays 0 until count = 4.
  - Pop down to count = 1 -> almost_empty = 1.
